// File: rtl/render_cmd_queue_pkg.sv
// Shared types and constants for the renderer command queue: register map,
// STATUS bit positions and the packed command word carried through the FIFO.
package render_pkg;

    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int CODE_W = 8;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_X      = 4'd1;
    localparam logic [3:0] ADDR_Y      = 4'd2;
    localparam logic [3:0] ADDR_CODE   = 4'd4;
    localparam logic [3:0] ADDR_GO     = 4'd6;
    localparam logic [3:0] ADDR_CTRL   = 4'd7;
    localparam logic [3:0] ADDR_DONE   = 4'd8;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_VALID     = 2;
    localparam int ST_BUSY      = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [Y_W-1:0]    y;
        logic [X_W-1:0]    x;
    } render_cmd_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RD_ACK = 1'b1
    } slave_state_t;

endpackage

// File: rtl/render_cmd_queue_if.sv
// CPU-side Avalon-MM slave bus plus the engine-side command/status port.
// The slave modport is the queue's view; master is the CPU/engine view.
interface render_cmd_queue_if;
    import render_pkg::*;

    logic [3:0]        slave_address;
    logic              slave_read;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic [31:0]       slave_readdata;
    logic              slave_waitrequest;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x;
    logic [Y_W-1:0]    cmd_y;
    logic [CODE_W-1:0] cmd_code;
    logic              engine_busy;
    logic              engine_done;

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata, slave_waitrequest,
        output cmd_valid, cmd_x, cmd_y, cmd_code,
        input  cmd_ready, engine_busy, engine_done
    );

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata, slave_waitrequest,
        input  cmd_valid, cmd_x, cmd_y, cmd_code,
        output cmd_ready, engine_busy, engine_done
    );

endinterface

// File: rtl/render_cmd_queue_fifo.sv
// Show-ahead synchronous FIFO of render commands; head is the oldest entry
// whenever the FIFO is not empty. Flush discards everything on the next edge.
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  render_cmd_t              din,
    output render_cmd_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    render_cmd_t    mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; empty/count gate every use of its contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

    assign head  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/render_cmd_queue.sv
// Avalon-MM front-end for the renderer: X/Y/CODE shadows, GO enqueues a
// command, registered valid/ready output stage, status and done counter.
//
//   state    | meaning
//   S_IDLE   | no read in progress; accepts writes, starts reads
//   S_RD_ACK | readdata registered last cycle; read completes now
module render_cmd_queue
    import render_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    render_cmd_queue_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    slave_state_t       state;
    slave_state_t       state_nxt;
    logic               rd_capture;
    logic               go_stall;
    logic               waitreq;
    logic               wr_en;
    logic               push;
    logic               pop;
    logic               flush;
    logic               load;

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [CODE_W-1:0]  code_q;
    logic [15:0]        done_cnt;
    logic [31:0]        rd_mux;
    logic [31:0]        readdata_q;

    render_cmd_t        shadow_cmd;
    render_cmd_t        head;
    render_cmd_t        cmd_q;
    logic               cmd_valid_q;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    wire unused_wdata = &{1'b0, bus.slave_writedata[31:X_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        rd_capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.slave_read) begin
                    rd_capture = 1'b1;
                    state_nxt  = S_RD_ACK;
                end
            end
            S_RD_ACK: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // GO stalls only on the registered full flag, never on the same-cycle pop.
    assign go_stall = bus.slave_write && (bus.slave_address == ADDR_GO) && fifo_full;
    assign waitreq  = rd_capture || go_stall;
    assign wr_en    = bus.slave_write && !waitreq;
    assign push     = wr_en && (bus.slave_address == ADDR_GO);
    assign flush    = wr_en && (bus.slave_address == ADDR_CTRL) && bus.slave_writedata[0];

    assign shadow_cmd = '{code: code_q, y: y_q, x: x_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            code_q <= '0;
        end else if (wr_en) begin
            case (bus.slave_address)
                ADDR_X:    x_q    <= bus.slave_writedata[X_W-1:0];
                ADDR_Y:    y_q    <= bus.slave_writedata[Y_W-1:0];
                ADDR_CODE: code_q <= bus.slave_writedata[CODE_W-1:0];
                default:   ;
            endcase
        end
    end

    // Clear beats a coincident engine_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done_cnt <= '0;
        else if (wr_en && (bus.slave_address == ADDR_DONE))
            done_cnt <= '0;
        else if (bus.engine_done && (done_cnt != 16'hFFFF))
            done_cnt <= done_cnt + 16'd1;
    end

    render_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (shadow_cmd),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign load = !cmd_valid_q || bus.cmd_ready;
    assign pop  = load && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
        end else if (load) begin
            cmd_valid_q <= !fifo_empty;
            if (!fifo_empty) cmd_q <= head;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.slave_address)
            ADDR_STATUS: begin
                rd_mux[ST_EMPTY]               = fifo_empty;
                rd_mux[ST_FULL]                = fifo_full;
                rd_mux[ST_VALID]               = cmd_valid_q;
                rd_mux[ST_BUSY]                = bus.engine_busy;
                rd_mux[ST_COUNT_LSB+7:ST_COUNT_LSB] = 8'(fifo_count);
            end
            ADDR_X:    rd_mux[X_W-1:0]    = x_q;
            ADDR_Y:    rd_mux[Y_W-1:0]    = y_q;
            ADDR_CODE: rd_mux[CODE_W-1:0] = code_q;
            ADDR_DONE: rd_mux[15:0]       = done_cnt;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             readdata_q <= '0;
        else if (rd_capture) readdata_q <= rd_mux;
    end

    assign bus.slave_readdata    = readdata_q;
    assign bus.slave_waitrequest = waitreq;
    assign bus.cmd_valid         = cmd_valid_q;
    assign bus.cmd_x             = cmd_q.x;
    assign bus.cmd_y             = cmd_q.y;
    assign bus.cmd_code          = cmd_q.code;

endmodule

// File: tb/tb_render_cmd_queue.sv
// Scoreboard bench for render_cmd_queue: directed scenarios plus a random
// phase, with commands checked in order by an independent output monitor.
module tb_render_cmd_queue;
    import render_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    render_cmd_queue_if bus();

    render_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    render_cmd_t        exp_q[$];
    render_cmd_t        mon_e;
    logic [X_W-1:0]     m_x;
    logic [Y_W-1:0]     m_y;
    logic [CODE_W-1:0]  m_code;
    int unsigned        m_done;
    logic               held_v = 1'b0;
    logic [31:0]        held_cmd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Output monitor: ordering against the scoreboard and hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 32'(bus.cmd_valid), 32'd1);
                check("hold_cmd", 32'({bus.cmd_code, bus.cmd_y, bus.cmd_x}), held_cmd);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got x=%0d y=%0d code=%h expected none at %0t",
                             bus.cmd_x, bus.cmd_y, bus.cmd_code, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd_x", 32'(bus.cmd_x), 32'(mon_e.x));
                    check("cmd_y", 32'(bus.cmd_y), 32'(mon_e.y));
                    check("cmd_code", 32'(bus.cmd_code), 32'(mon_e.code));
                end
            end
            held_v   = bus.cmd_valid && !bus.cmd_ready;
            held_cmd = 32'({bus.cmd_code, bus.cmd_y, bus.cmd_x});
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic avm_write(input logic [3:0] a, input logic [31:0] d, output int waits);
        bit timed_out;
        timed_out = 1'b0;
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!bus.slave_waitrequest) break;
            waits++;
            if (waits > 1000) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
        if (timed_out) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: got waitrequest stuck expected completion addr=%0d", a);
        end else begin
            case (a)
                ADDR_X:    m_x    = d[X_W-1:0];
                ADDR_Y:    m_y    = d[Y_W-1:0];
                ADDR_CODE: m_code = d[CODE_W-1:0];
                ADDR_GO:   exp_q.push_back('{code: m_code, y: m_y, x: m_x});
                ADDR_CTRL: if (d[0] && exp_q.size() > 1) exp_q = exp_q[0:0];
                ADDR_DONE: m_done = 0;
                default:   ;
            endcase
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        int w;
        avm_write(a, d, w);
        if (a != ADDR_GO) check("wr_nowait", 32'(w), 32'd0);
    endtask

    task automatic avm_read(input string name, input logic [3:0] a, input logic [31:0] req);
        int waits;
        logic [31:0] d;
        d = '0;
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!bus.slave_waitrequest) begin
                d = bus.slave_readdata;
                break;
            end
            waits++;
            if (waits > 100) break;
        end
        @(posedge clk);
        #1;
        bus.slave_read = 1'b0;
        check("rd_waits", 32'(waits), 32'd1);
        check(name, d, req);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic done_pulse();
        bus.engine_done = 1'b1;
        idle(1);
        bus.engine_done = 1'b0;
        if (m_done < 65535) m_done++;
    endtask

    task automatic drain();
        int n;
        bus.cmd_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.cmd_valid) && n < 200) begin
            idle(1);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(bus.cmd_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] ra;
        rst = 1'b1;
        bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0;
        bus.slave_writedata = '0; bus.cmd_ready = 1'b0;
        bus.engine_busy = 1'b0; bus.engine_done = 1'b0;
        m_x = '0; m_y = '0; m_code = '0; m_done = 0;

        // 1: reset state
        idle(3);
        check("rst_readdata", bus.slave_readdata, 32'd0);
        check("rst_waitreq", 32'(bus.slave_waitrequest), 32'd0);
        check("rst_valid", 32'(bus.cmd_valid), 32'd0);
        rst = 1'b0;
        idle(1);
        avm_read("status_reset", ADDR_STATUS, 32'h0000_0001);

        // 2: single command, one-cycle latency, done counter
        wr(ADDR_X, 32'd20); wr(ADDR_Y, 32'd20); wr(ADDR_CODE, 32'h01);
        bus.cmd_ready = 1'b1;
        avm_write(ADDR_GO, 32'd0, w);
        check("go_nowait", 32'(w), 32'd0);
        @(negedge clk);
        check("lat_valid0", 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        check("lat_valid1", 32'(bus.cmd_valid), 32'd1);
        check("lat_x", 32'(bus.cmd_x), 32'd20);
        @(posedge clk); #1;
        done_pulse();
        avm_read("done_one", ADDR_DONE, 32'(m_done));
        drain();

        // 3: fill to full, stalled GO, release one slot
        bus.cmd_ready = 1'b0;
        bus.engine_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr(ADDR_X, 32'(100 + i));
            avm_write(ADDR_GO, 32'd0, w);
            check("fill_nowait", 32'(w), 32'd0);
        end
        avm_read("status_full", ADDR_STATUS, 32'h0000_080E);
        wr(ADDR_X, 32'd109);
        fork
            avm_write(ADDR_GO, 32'd0, w);
            begin
                repeat (3) @(negedge clk);
                check("stall_waitreq", 32'(bus.slave_waitrequest), 32'd1);
                @(posedge clk); #1;
                bus.cmd_ready = 1'b1;
                @(posedge clk); #1;
                bus.cmd_ready = 1'b0;
            end
        join
        check("stall_waits", 32'(w), 32'd4);
        avm_read("status_refull", ADDR_STATUS, 32'h0000_080E);
        bus.engine_busy = 1'b0;
        drain();

        // 4: flush keeps the held output command
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(ADDR_X, 32'(40 + i));
            avm_write(ADDR_GO, 32'd0, w);
        end
        idle(2);
        wr(ADDR_CTRL, 32'd1);
        avm_read("status_flush", ADDR_STATUS, 32'h0000_0005);
        check("flush_keep_x", 32'(bus.cmd_x), 32'(exp_q[0].x));
        idle(3);
        drain();

        // 5: repeated GO, shadow readback, truncation, unmapped space
        wr(ADDR_X, 32'd159); wr(ADDR_Y, 32'd239); wr(ADDR_CODE, 32'h09);
        avm_write(ADDR_GO, 32'd0, w);
        avm_write(ADDR_GO, 32'd0, w);
        drain();
        avm_read("rb_x", ADDR_X, 32'd159);
        avm_read("rb_y", ADDR_Y, 32'd239);
        avm_read("rb_code", ADDR_CODE, 32'h09);
        wr(ADDR_X, 32'hFFFF_FFFF);
        wr(4'd5, 32'h0000_0003);
        avm_read("rb_x_trunc", ADDR_X, 32'h0000_01FF);
        avm_read("rd_unmapped3", 4'd3, 32'd0);
        avm_read("rd_go", ADDR_GO, 32'd0);
        avm_read("rd_unmapped15", 4'd15, 32'd0);

        // random traffic against the scoreboard and shadow model
        for (int i = 0; i < 400; i++) begin
            bus.cmd_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 10))
                0, 1: wr(ADDR_X, $urandom);
                2:    wr(ADDR_Y, $urandom);
                3:    wr(ADDR_CODE, $urandom);
                4, 5, 6: begin
                    if (exp_q.size() >= DEPTH) bus.cmd_ready = 1'b1;
                    avm_write(ADDR_GO, $urandom, w);
                end
                7: begin
                    ra = ($urandom_range(0, 2) == 0) ? ADDR_X :
                         ($urandom_range(0, 1) == 0) ? ADDR_Y : ADDR_CODE;
                    avm_read("rnd_shadow", ra,
                             (ra == ADDR_X) ? 32'(m_x) : (ra == ADDR_Y) ? 32'(m_y) : 32'(m_code));
                end
                8:  done_pulse();
                9:  avm_read("rnd_done", ADDR_DONE, 32'(m_done));
                default: wr(ADDR_DONE, 32'd0);
            endcase
        end
        drain();

        // 6: reset mid-operation, then saturation and clear priority
        bus.cmd_ready = 1'b0;
        wr(ADDR_X, 32'd5);
        for (int i = 0; i < 5; i++) avm_write(ADDR_GO, 32'd0, w);
        avm_read("pre_rst_x", ADDR_X, 32'd5);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_mid_cmd", 32'({bus.cmd_code, bus.cmd_y, bus.cmd_x}), 32'd0);
        check("rst_mid_readdata", bus.slave_readdata, 32'd0);
        check("rst_mid_waitreq", 32'(bus.slave_waitrequest), 32'd0);
        exp_q.delete();
        m_x = '0; m_y = '0; m_code = '0; m_done = 0;
        idle(1);
        rst = 1'b0;
        idle(1);
        avm_read("status_post_rst", ADDR_STATUS, 32'h0000_0001);
        avm_read("x_post_rst", ADDR_X, 32'd0);

        bus.engine_done = 1'b1;
        idle(65540);
        bus.engine_done = 1'b0;
        m_done = 65535;
        avm_read("done_saturate", ADDR_DONE, 32'(m_done));
        bus.engine_done = 1'b1;
        wr(ADDR_DONE, 32'd0);
        bus.engine_done = 1'b0;
        avm_read("done_clear_wins", ADDR_DONE, 32'd0);
        done_pulse();
        avm_read("done_after_clear", ADDR_DONE, 32'(m_done));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
